// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int N_ROWS     = 4;
    localparam int N_COLS     = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        EVAL,
        REPORT,
        WAIT_RELEASE
    } state_t;

    function automatic logic [N_COLS-1:0] onehot_col(input logic [1:0] idx);
        logic [N_COLS-1:0] one;
        one = {{(N_COLS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_row_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module row_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: debounces a press, walks the columns to locate a
// single key, reports it with a one-cycle pulse, then waits for release.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_ROWS-1:0]     Row,
    output logic [N_COLS-1:0]     Col,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  busy
);

    localparam int             CW          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int             HIT_W       = N_ROWS * N_COLS;
    localparam logic [CW-1:0]  DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [N_ROWS-1:0]     row_s;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [CW-1:0]         settle, settle_n;
    logic [1:0]            col_idx, col_idx_n;
    logic [HIT_W-1:0]      hit, hit_n;
    logic [3:0]            hit_pos;
    logic [KEY_CODE_W-1:0] code_n;
    logic                  valid_n;
    logic [N_COLS-1:0]     col_n;
    logic                  busy_n;

    row_sync2 #(
        .WIDTH(N_ROWS)
    ) u_row_sync (
        .clk  (clock),
        .rst_n(reset),
        .d    (Row),
        .q    (row_s)
    );

    // Hit vector is column-major: bit index = col*N_ROWS + row.
    always_comb begin
        hit_pos = '0;
        for (int unsigned i = 0; i < HIT_W; i++) begin
            if (hit[i]) hit_pos = 4'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            settle    <= '0;
            col_idx   <= '0;
            hit       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            Col       <= '1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            settle    <= settle_n;
            col_idx   <= col_idx_n;
            hit       <= hit_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            Col       <= col_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        settle_n  = settle;
        col_idx_n = col_idx;
        hit_n     = hit;
        code_n    = key_code;
        valid_n   = 1'b0;

        case (state)
            IDLE: begin
                if (row_s != '0) begin
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            DEBOUNCE: begin
                if (row_s == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = SCAN;
                    cnt_n     = '0;
                    settle_n  = '0;
                    col_idx_n = '0;
                    hit_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SCAN: begin
                if (settle == SETTLE_LAST) begin
                    hit_n[int'(col_idx)*N_ROWS +: N_ROWS] =
                        hit[int'(col_idx)*N_ROWS +: N_ROWS] | row_s;
                    settle_n = '0;
                    if (col_idx == 2'(N_COLS - 1)) state_n = EVAL;
                    else                           col_idx_n = col_idx + 1'b1;
                end else begin
                    settle_n = settle + 1'b1;
                end
            end
            EVAL: begin
                cnt_n = '0;
                // Key code is row-major, hit vector is column-major: swap halves.
                if ($countones(hit) == 1) begin
                    state_n = REPORT;
                    code_n  = {hit_pos[1:0], hit_pos[3:2]};
                    valid_n = 1'b1;
                end else begin
                    state_n = WAIT_RELEASE;
                end
            end
            REPORT: begin
                state_n = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (row_s != '0) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        col_n  = (state_n == SCAN) ? onehot_col(col_idx_n) : '1;
        busy_n = (state_n != IDLE);
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 lock keypad matrix. It drives the column lines and synchronizes and debounces the row lines. It walks the columns to locate a single pressed key, then emits a one-cycle `key_valid` pulse with a 4-bit key code to the lock FSM downstream. It replaces the plain OR of the row lines with a full press/scan/release sequence.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2000000: consecutive stable cycles required for press and for release (40 ms at 50 MHz); must be ≥ 2.
- `SETTLE_CYCLES`, default 8: cycles each column is driven before its rows are sampled; must be ≥ 3, to cover the synchronizer.

Ports:
- `clock`: in, 1 bit. System clock; all logic on the rising edge.
- `reset`: in, 1 bit. Asynchronous, active-low reset.
- `Row`: in, 4 bits. Raw keypad row lines, asynchronous; active-high when a key in the driven column is pressed.
- `Col`: out, 4 bits. Column drive, active-high.
- `key_code`: out, 4 bits. Last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid`: out, 1 bit. One-cycle pulse; `key_code` is valid in this cycle and holds afterwards.
- `busy`: out, 1 bit. High in every state except IDLE.

## Operation
- **Row synchronization:** `Row` passes through a 2-flop synchronizer, giving `row_s`. All decisions use `row_s` only.
- **Reset values:** state = IDLE, `Col` = 4'b1111, `key_code` = 0, `key_valid` = 0, `busy` = 0; all counters and the hit register cleared. Reset mid-operation aborts any state immediately; no `key_valid` is emitted.
- **States:**
  - **IDLE:** `Col` = 1111. If `row_s` != 0, go to DEBOUNCE with the count at 0.
  - **DEBOUNCE:** `Col` = 1111. The count increments each cycle while `row_s` != 0.
    - If `row_s` == 0 in any cycle, go to IDLE; no output.
    - When the count reaches `DEBOUNCE_CYCLES`-1 with `row_s` != 0, go to SCAN with `col_idx` = 0, the settle count at 0 and the hit register cleared.
  - **SCAN:** `Col` = one-hot(`col_idx`), LSB = column 0. The settle count runs 0..`SETTLE_CYCLES`-1.
    - On the last settle cycle, `row_s` is ORed into the 16-bit hit vector at bits `[col_idx*4 +: 4]`, then `col_idx` advances.
    - After column 3 is sampled, go to EVAL.
  - **EVAL (1 cycle):**
    - If exactly one hit bit is set, go to REPORT with that bit's row/col index latched.
    - If zero hits (key released during scan) or two or more hits (multi-key/ghosting), go to WAIT_RELEASE with no report.
  - **REPORT (1 cycle):** `key_valid` = 1 and `key_code` updated in this same cycle. Go to WAIT_RELEASE.
  - **WAIT_RELEASE:** `Col` = 1111. The release count increments while `row_s` == 0 and clears to 0 when `row_s` != 0.
    - At `DEBOUNCE_CYCLES`-1 with `row_s` == 0, go to IDLE.
- **Counters:** width = $clog2(`DEBOUNCE_CYCLES`+1); no wrap is possible because every counter is bounded by its state exit.
- **Held key:** a held key produces exactly one report. Auto-repeat is not supported.

## Timing
- Let T be the first cycle IDLE sees `row_s` != 0 (2 cycles after the `Row` edge). Then:
  - DEBOUNCE occupies T+1 .. T+D, where D = `DEBOUNCE_CYCLES`.
  - SCAN occupies T+D+1 .. T+D+4S, where S = `SETTLE_CYCLES`.
  - EVAL is at T+D+4S+1.
  - `key_valid` is high at T+D+4S+2.
- `key_valid` is never high on two consecutive cycles. The minimum spacing between two reports is 2D+4S+3 cycles.
- `busy` rises in cycle T+1 and falls in the cycle IDLE is re-entered.
- `Col` changes only at state or `col_idx` transitions and is registered (no glitches).

## Structure
- **Package `keypad_pkg`:**
  - state enum: IDLE, DEBOUNCE, SCAN, EVAL, REPORT, WAIT_RELEASE;
  - `KEY_CODE_W` = 4, `N_ROWS` = 4, `N_COLS` = 4;
  - function `onehot_col(idx)`.
- **Sub-module `row_sync2`:** a parameterized-width 2-flop synchronizer, instantiated once for `Row`.
- **Top level:** the FSM, counters and hit vector live in `keypad_scan_ctrl`.

## Test plan
All scenarios use D = 16, S = 4.
- **Clean single press:** press (row 2, col 1) held 200 cycles, model drives `Row` = `Col`[1] ? 4'b0100 : 0 -> one `key_valid` at T+34 with `key_code` = 4'b1001; `busy` falls 16 cycles after release.
- **Bounce:** 6 cycles high, 3 low, then held -> no SCAN before a 16-cycle stable run; exactly one `key_valid`.
- **Glitch:** `Row` pulse shorter than 16 cycles -> return to IDLE, no `key_valid`, `Col` stays 1111.
- **Two keys:** (0,0) and (3,3) held simultaneously -> EVAL sees 2 hits, no `key_valid`, WAIT_RELEASE until both released.
- **Early release:** release after DEBOUNCE but before column 1 is sampled -> zero hits, no report, then IDLE.
- **Reset mid-SCAN:** assert reset during SCAN -> asynchronously `Col` = 1111, `busy` = 0, `key_code` = 0; a later press reports normally.
